frame_buffer: RTL and testbench

FRAME_BUFFER -- requirements
Module: frame_buffer

---
 rtl/frame_buffer_pkg.sv | 12 +
 rtl/frame_ram.sv | 22 ++
 rtl/frame_buffer.sv | 103 ++++++++++
 tb/tb_frame_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared defaults and overflow-policy encoding for the frame buffer slice.
package frame_buffer_pkg;

   localparam int unsigned FRAMEWIDTH_DEF  = 128;
   localparam int unsigned BUFFLENLOG2_DEF = 9;
   localparam int unsigned OVFCNTWIDTH_DEF = 16;

   // DropOldest encoding: what happens to a packet arriving while full.
   localparam logic POLICY_DROP_INCOMING = 1'b0;
   localparam logic POLICY_DROP_OLDEST   = 1'b1;

endpackage

// File: rtl/frame_ram.sv
// Frame storage: one synchronous write port, one asynchronous read port.
module frame_ram #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned ADDRW = 9
) (
   input  logic             clk,
   input  logic             wrEn,
   input  logic [ADDRW-1:0] wrAddr,
   input  logic [WIDTH-1:0] wrData,
   input  logic [ADDRW-1:0] rdAddr,
   output logic [WIDTH-1:0] rdData
);

   logic [WIDTH-1:0] mem [2**ADDRW];

   always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/frame_buffer.sv
// Circular first-word-fall-through frame FIFO with overflow policy,
// sticky overflow flag/counter and a registered high-water indication.
module frame_buffer
   import frame_buffer_pkg::*;
#(
   parameter int unsigned FRAMEWIDTH  = FRAMEWIDTH_DEF,
   parameter int unsigned BUFFLENLOG2 = BUFFLENLOG2_DEF,
   parameter int unsigned OVFCNTWIDTH = OVFCNTWIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   PkAvail,
   input  logic [FRAMEWIDTH-1:0]  Packet,
   output logic [FRAMEWIDTH-1:0]  Frame,
   input  logic                   FrameNext,
   output logic [BUFFLENLOG2:0]   FramesCnt,
   input  logic                   Flush,
   input  logic                   DropOldest,
   input  logic [BUFFLENLOG2:0]   HighWaterLvl,
   output logic                   HighWater,
   output logic                   DataOverf,
   input  logic                   OverfClr,
   output logic [OVFCNTWIDTH-1:0] OverfCnt
);

   localparam int unsigned DEPTH = 2**BUFFLENLOG2;
   localparam int unsigned CNTW  = BUFFLENLOG2 + 1;

   logic [BUFFLENLOG2-1:0] head, tail, headNext, tailNext;
   logic [CNTW-1:0]        cntNext;
   logic                   full, popOk, wrEn, ovfEvent;
   logic                   dataOverfNext;
   logic [OVFCNTWIDTH-1:0] overfCntNext;

   // Pointer/count next state; Flush overrides everything else.
   always_comb begin
      headNext = head;
      tailNext = tail;
      cntNext  = FramesCnt;
      wrEn     = 1'b0;
      ovfEvent = 1'b0;
      full     = (FramesCnt == CNTW'(DEPTH));
      popOk    = FrameNext && (FramesCnt != '0);
      if (Flush) begin
         headNext = '0;
         tailNext = '0;
         cntNext  = '0;
      end else begin
         ovfEvent = PkAvail && full && !popOk;
         wrEn     = PkAvail && (!ovfEvent || (DropOldest == POLICY_DROP_OLDEST));
         if (wrEn) tailNext = tail + BUFFLENLOG2'(1);
         // Overwriting while full retires the oldest entry with the new write.
         if (popOk || (ovfEvent && wrEn)) headNext = head + BUFFLENLOG2'(1);
         if (wrEn && !popOk && !ovfEvent)   cntNext = FramesCnt + CNTW'(1);
         else if (popOk && !wrEn)           cntNext = FramesCnt - CNTW'(1);
      end
   end

   // Overflow flag/counter; an event in the clearing cycle still counts.
   always_comb begin
      dataOverfNext = DataOverf;
      overfCntNext  = OverfCnt;
      if (ovfEvent) begin
         dataOverfNext = 1'b1;
         if (OverfClr)              overfCntNext = OVFCNTWIDTH'(1);
         else if (OverfCnt != '1)   overfCntNext = OverfCnt + OVFCNTWIDTH'(1);
      end else if (OverfClr) begin
         dataOverfNext = 1'b0;
         overfCntNext  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head      <= '0;
         tail      <= '0;
         FramesCnt <= '0;
         DataOverf <= 1'b0;
         OverfCnt  <= '0;
         HighWater <= 1'b0;
      end else begin
         head      <= headNext;
         tail      <= tailNext;
         FramesCnt <= cntNext;
         DataOverf <= dataOverfNext;
         OverfCnt  <= overfCntNext;
         HighWater <= (FramesCnt >= HighWaterLvl);
      end
   end

   frame_ram #(
      .WIDTH (FRAMEWIDTH),
      .ADDRW (BUFFLENLOG2)
   ) uRam (
      .clk    (clk),
      .wrEn   (wrEn && rst),
      .wrAddr (tail),
      .wrData (Packet),
      .rdAddr (head),
      .rdData (Frame)
   );

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer (depth 4) against a queue-based model.
module tb_frame_buffer;

   localparam int unsigned FW    = 16;
   localparam int unsigned LOG2  = 2;
   localparam int unsigned OVW   = 3;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned OVMAX = 7;

   logic            clk_tb = 1'b0;
   logic            rst;
   logic            PkAvail;
   logic [FW-1:0]   Packet;
   logic [FW-1:0]   Frame;
   logic            FrameNext;
   logic [LOG2:0]   FramesCnt;
   logic            Flush;
   logic            DropOldest;
   logic [LOG2:0]   HighWaterLvl;
   logic            HighWater;
   logic            DataOverf;
   logic            OverfClr;
   logic [OVW-1:0]  OverfCnt;

   int errors = 0;
   int checks = 0;

   logic [FW-1:0] q[$];
   bit            mOvf;
   int            mCnt;
   bit            mHw;

   always #5 clk_tb = ~clk_tb;

   frame_buffer #(
      .FRAMEWIDTH  (FW),
      .BUFFLENLOG2 (LOG2),
      .OVFCNTWIDTH (OVW)
   ) dut (
      .clk          (clk_tb),
      .rst          (rst),
      .PkAvail      (PkAvail),
      .Packet       (Packet),
      .Frame        (Frame),
      .FrameNext    (FrameNext),
      .FramesCnt    (FramesCnt),
      .Flush        (Flush),
      .DropOldest   (DropOldest),
      .HighWaterLvl (HighWaterLvl),
      .HighWater    (HighWater),
      .DataOverf    (DataOverf),
      .OverfClr     (OverfClr),
      .OverfCnt     (OverfCnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll();
      chk("cnt", 32'(FramesCnt), 32'(q.size()));
      if (q.size() != 0) chk("frame", 32'(Frame), 32'(q[0]));
      chk("ovf", 32'(DataOverf), 32'(mOvf));
      chk("ovfcnt", 32'(OverfCnt), 32'(mCnt));
      chk("hw", 32'(HighWater), 32'(mHw));
   endtask

   // Apply one cycle of inputs, advance the model, then compare after the edge.
   task automatic step(input bit r, input bit pk, input logic [FW-1:0] pkt,
                       input bit nxt, input bit fl, input bit drp, input bit clr);
      bit popOk;
      bit ev;
      bit hwNew;
      rst = r; PkAvail = pk; Packet = pkt; FrameNext = nxt;
      Flush = fl; DropOldest = drp; OverfClr = clr;
      if (!r) begin
         q.delete(); mOvf = 0; mCnt = 0; mHw = 0;
      end else begin
         hwNew = (q.size() >= int'(HighWaterLvl));
         ev = 0;
         if (fl) q.delete();
         else begin
            popOk = nxt && (q.size() != 0);
            if (pk && q.size() == DEPTH && !popOk) begin
               ev = 1;
               if (drp) begin
                  void'(q.pop_front());
                  q.push_back(pkt);
               end
            end else begin
               if (popOk) void'(q.pop_front());
               if (pk) q.push_back(pkt);
            end
         end
         if (ev) begin
            mOvf = 1;
            mCnt = clr ? 1 : ((mCnt == OVMAX) ? OVMAX : mCnt + 1);
         end else if (clr) begin
            mOvf = 0; mCnt = 0;
         end
         mHw = hwNew;
      end
      @(posedge clk_tb);
      #1;
      checkAll();
   endtask

   task automatic push(input int v, input bit drp);
      step(1, 1, FW'(v), 0, 0, drp, 0);
   endtask

   task automatic popExpect(input string tag, input int v);
      chk(tag, 32'(Frame), 32'(v));
      step(1, 0, '0, 1, 0, 0, 0);
   endtask

   task automatic idle(input bit clr);
      step(1, 0, '0, 0, 0, 0, clr);
   endtask

   initial begin
      HighWaterLvl = 3'(4);
      step(0, 0, '0, 0, 0, 0, 0);
      step(0, 1, FW'(9), 1, 0, 0, 0);
      chk("rst_cnt", 32'(FramesCnt), 0);
      chk("rst_hw", 32'(HighWater), 0);

      // Full, drop incoming
      for (int i = 1; i <= 4; i++) push(i, 0);
      push(5, 0);
      chk("r34_cnt", 32'(FramesCnt), 4);
      chk("r34_ovf", 32'(DataOverf), 1);
      chk("r34_ovfcnt", 32'(OverfCnt), 1);
      for (int i = 1; i <= 4; i++) popExpect("r34_pop", i);
      idle(1);

      // Full, overwrite oldest
      for (int i = 1; i <= 4; i++) push(i, 1);
      push(5, 1);
      chk("r35_cnt", 32'(FramesCnt), 4);
      chk("r35_ovfcnt", 32'(OverfCnt), 1);
      for (int i = 2; i <= 5; i++) popExpect("r35_pop", i);
      idle(1);

      // Full with simultaneous push and pop
      for (int i = 1; i <= 4; i++) push(i, 0);
      step(1, 1, FW'(5), 1, 0, 0, 0);
      chk("r36_cnt", 32'(FramesCnt), 4);
      chk("r36_ovf", 32'(DataOverf), 0);
      for (int i = 2; i <= 5; i++) popExpect("r36_pop", i);

      // Streaming one per cycle across pointer wrap
      push(1, 0);
      for (int i = 2; i <= 10; i++) begin
         chk("r37_order", 32'(Frame), 32'(i - 1));
         step(1, 1, FW'(i), 1, 0, 0, 0);
         chk("r37_cnt", 32'(FramesCnt), 1);
      end
      popExpect("r37_last", 10);
      chk("r37_ovf", 32'(DataOverf), 0);

      // Flush beats a simultaneous push
      for (int i = 1; i <= 3; i++) push(i, 0);
      step(1, 1, FW'(99), 0, 1, 0, 0);
      chk("r38_cnt", 32'(FramesCnt), 0);
      chk("r38_ovf", 32'(DataOverf), 0);
      push(7, 0);
      popExpect("r38_first", 7);

      // High water and mid-stream reset
      HighWaterLvl = 3'(3);
      for (int i = 1; i <= 3; i++) push(i, 0);
      chk("r39_hw_lag", 32'(HighWater), 0);
      idle(0);
      chk("r39_hw", 32'(HighWater), 1);
      step(0, 1, FW'(8), 1, 0, 0, 0);
      chk("r39_rst_cnt", 32'(FramesCnt), 0);
      chk("r39_rst_hw", 32'(HighWater), 0);
      push(42, 0);
      popExpect("r39_after_rst", 42);

      // Counter saturation and clear/event collision
      for (int i = 1; i <= 4; i++) push(i, 0);
      for (int i = 0; i < 9; i++) push(100 + i, 0);
      chk("sat_cnt", 32'(OverfCnt), OVMAX);
      step(1, 1, FW'(200), 0, 0, 0, 1);
      chk("clr_evt", 32'(OverfCnt), 1);
      idle(1);
      chk("clr_only", 32'(OverfCnt), 0);

      // Zero threshold forces HighWater
      HighWaterLvl = '0;
      step(1, 0, '0, 0, 1, 0, 0);
      idle(0);
      chk("hw_zero", 32'(HighWater), 1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0) HighWaterLvl = 3'($urandom_range(0, 4));
         step($urandom_range(0, 49) != 0,
              $urandom_range(0, 2) != 0,
              FW'($urandom),
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 14) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
